// File: rtl/com_event_logger.sv
// Change-of-state logger for the filtered active-low command vector: time-tagged
// records in a small FIFO with overflow flag and resync record. Timestamp gated by COM_EVENT_TS_EN.
`default_nettype none

module com_event_logger #(
   parameter int NUM_SIGNALS = 16,
   parameter int DEPTH_LOG2  = 3,
   parameter int TS_WIDTH    = 16
`ifdef COM_EVENT_TS_EN
   , localparam int REC_W    = TS_WIDTH + NUM_SIGNALS
`else
   , localparam int REC_W    = NUM_SIGNALS
`endif
) (
   input  logic                   clk,
   input  logic                   sclr_n,
   input  logic [NUM_SIGNALS-1:0] com_in,
   input  logic                   tick,
   input  logic                   rd_req,
   output logic [REC_W-1:0]       rd_data,
   output logic                   rd_valid,
   output logic                   empty,
   output logic                   full,
   output logic [DEPTH_LOG2:0]    level,
   output logic                   overflow,
   input  logic                   ovf_clr
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [REC_W-1:0]       mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wptr;
   logic [DEPTH_LOG2-1:0]  rptr;
   logic [NUM_SIGNALS-1:0] prev;
   logic                   resync;
   logic [REC_W-1:0]       rec;

   logic pop;
   logic full_eff;
   logic changed;
   logic push_req;
   logic push;
   logic drop;

`ifdef COM_EVENT_TS_EN
   logic [TS_WIDTH-1:0] ts;

   always_ff @(posedge clk) begin
      if (!sclr_n)
         ts <= '0;
      else if (tick)
         ts <= ts + 1'b1;
   end

   assign rec = {ts, com_in};
`else
   logic                unused_tick;
   logic [TS_WIDTH-1:0] unused_ts_w;

   assign unused_tick = tick;
   assign unused_ts_w = '0;
   assign rec         = com_in;
`endif

   assign empty    = (level == '0);
   assign full     = (level == LVL_FULL);
   assign pop      = rd_req & ~empty;
   assign full_eff = full & ~pop;
   assign changed  = (com_in != prev);
   assign push_req = changed | (resync & ~full_eff);
   assign push     = push_req & ~full_eff;
   // Only a real change can be dropped; the resync term is already masked by full_eff.
   assign drop     = push_req & full_eff;

   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         prev     <= '1;
         resync   <= 1'b0;
         overflow <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         prev     <= com_in;
         rd_valid <= pop;
         if (pop) begin
            rd_data <= mem[rptr];
            rptr    <= rptr + 1'b1;
         end
         if (push)
            wptr <= wptr + 1'b1;
         if (drop)
            resync <= 1'b1;
         else if (push)
            resync <= 1'b0;
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset; pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= rec;
   end

endmodule

`default_nettype wire

// File: tb/tb_com_event_logger.sv
// Bench for com_event_logger: directed test-plan steps plus random traffic,
// every cycle compared against a queue-based reference model.
`timescale 1ns/1ps

module tb_com_event_logger;

`ifdef COM_EVENT_TS_EN
   localparam int RW = 32;
`else
   localparam int RW = 16;
`endif

   typedef logic [RW-1:0] rec_t;

   logic        clk = 1'b0;
   logic        sclr_n;
   logic [15:0] com_in;
   logic        tick;
   logic        rd_req;
   rec_t        rd_data;
   logic        rd_valid;
   logic        empty;
   logic        full;
   logic [3:0]  level;
   logic        overflow;
   logic        ovf_clr;

   int n_pass = 0;
   int n_total = 0;

   com_event_logger #(.NUM_SIGNALS(16), .DEPTH_LOG2(3), .TS_WIDTH(16)) dut (
      .clk(clk), .sclr_n(sclr_n), .com_in(com_in), .tick(tick), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
      .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // Reference model: records as a queue, timestamp as a plain counter.
   rec_t        q[$];
   logic [15:0] m_prev;
   bit          m_resync;
   bit          m_ovf;
   bit          m_valid;
   rec_t        m_data;
   int unsigned m_ts;

   function automatic rec_t mkrec(input int unsigned t, input logic [15:0] v);
`ifdef COM_EVENT_TS_EN
      return {t[15:0], v};
`else
      return v;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_edge();
      bit popok, fe, chg;
      if (!sclr_n) begin
         q.delete();
         m_prev = '1; m_ts = 0; m_resync = 0; m_ovf = 0; m_valid = 0; m_data = '0;
      end else begin
         popok   = rd_req && (q.size() != 0);
         fe      = (q.size() == 8) && !popok;
         chg     = (com_in != m_prev);
         m_valid = popok;
         if (popok) m_data = q.pop_front();
         if (!fe && (chg || m_resync)) begin
            q.push_back(mkrec(m_ts, com_in));
            m_resync = 0;
         end
         if (fe && chg) begin
            m_ovf = 1;
            m_resync = 1;
         end else if (ovf_clr) begin
            m_ovf = 0;
         end
         m_prev = com_in;
         if (tick) m_ts = (m_ts + 1) % 65536;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("level", 64'(level), 64'(q.size()));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("full", 64'(full), 64'(q.size() == 8));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("rd_valid", 64'(rd_valid), 64'(m_valid));
      chk("rd_data", 64'(rd_data), 64'(m_data));
   endtask

   task automatic cyc(input logic [15:0] c, input bit t, input bit r, input bit clr);
      com_in = c; tick = t; rd_req = r; ovf_clr = clr;
      step();
   endtask

   initial begin
      sclr_n = 1'b0; com_in = 16'hFFFF; tick = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0;
      step(); step();
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_data", 64'(rd_data), 64'd0);
      sclr_n = 1'b1;

      // Idle vector held: nothing recorded, reads while empty ignored.
      for (int i = 0; i < 20; i++) cyc(16'hFFFF, 1'b0, i[0], 1'b0);
      chk("idle_valid", 64'(rd_valid), 64'd0);

      // Five ticks then one change.
      for (int i = 0; i < 5; i++) cyc(16'hFFFF, 1'b1, 1'b0, 1'b0);
      cyc(16'hFFFE, 1'b0, 1'b0, 1'b0);
      chk("tp2_level", 64'(level), 64'd1);
      cyc(16'hFFFE, 1'b0, 1'b1, 1'b0);
      chk("tp2_data", 64'(rd_data), 64'(mkrec(5, 16'hFFFE)));
      chk("tp2_valid", 64'(rd_valid), 64'd1);
      cyc(16'hFFFE, 1'b0, 1'b0, 1'b0);
      chk("tp2_valid_drop", 64'(rd_valid), 64'd0);

      // Nine changes with no reads: overflow, then resync after one pop.
      for (int i = 0; i < 9; i++) cyc(16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0);
      cyc(16'h1008, 1'b0, 1'b0, 1'b0);
      chk("ovf_full", 64'(full), 64'd1);
      chk("ovf_flag", 64'(overflow), 64'd1);
      cyc(16'h1008, 1'b0, 1'b1, 1'b0);
      cyc(16'h1008, 1'b0, 1'b0, 1'b0);
      chk("resync_level", 64'(level), 64'd8);
      for (int i = 0; i < 9; i++) cyc(16'h1008, 1'b0, 1'b1, 1'b0);
      chk("resync_last", 64'(rd_data), 64'(mkrec(m_ts, 16'h1008)));

      // Full FIFO with pop and change in the same cycle.
      cyc(16'h1008, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cyc(16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
      cyc(16'h2100, 1'b0, 1'b1, 1'b0);
      chk("swap_level", 64'(level), 64'd8);
      chk("swap_ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 9; i++) cyc(16'h2100, 1'b0, 1'b1, 1'b0);

      // Timestamp wrap.
      sclr_n = 1'b0; cyc(16'hFFFF, 1'b0, 1'b0, 1'b0); sclr_n = 1'b1;
      for (int i = 0; i < 65535; i++) cyc(16'hFFFF, 1'b1, 1'b0, 1'b0);
      cyc(16'hFFF0, 1'b1, 1'b0, 1'b0);
      cyc(16'hFFF1, 1'b0, 1'b0, 1'b0);
      cyc(16'hFFF1, 1'b0, 1'b1, 1'b0);
      chk("wrap_ts_max", 64'(rd_data), 64'(mkrec(16'hFFFF, 16'hFFF0)));
      cyc(16'hFFF1, 1'b0, 1'b1, 1'b0);
      chk("wrap_ts_zero", 64'(rd_data), 64'(mkrec(0, 16'hFFF1)));

      // Reset with records queued, released with a command held active.
      for (int i = 1; i <= 4; i++) cyc(16'hFF00 + 16'(i), 1'b1, 1'b0, 1'b0);
      sclr_n = 1'b0; cyc(16'hFF00, 1'b1, 1'b0, 1'b0);
      chk("rst_mid_level", 64'(level), 64'd0);
      sclr_n = 1'b1;
      cyc(16'hFF00, 1'b0, 1'b0, 1'b0);
      chk("post_rst_level", 64'(level), 64'd1);
      cyc(16'hFF00, 1'b0, 1'b1, 1'b0);
      chk("post_rst_data", 64'(rd_data), 64'(mkrec(0, 16'hFF00)));

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] c;
         c = com_in;
         if ($urandom_range(0, 1) == 0) c = 16'hF000 | 16'($urandom_range(0, 5));
         sclr_n = ($urandom_range(0, 99) != 0);
         cyc(c, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
      end
      sclr_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/com_event_logger.md
# com_event_logger

Records every change of the filtered, active-low command vector produced by the command input filter. Each record holds a timestamp and the new vector. Records go into a small FIFO that the host side drains with a request/valid read handshake. It sits directly downstream of the input filter and turns level-coded command states into an ordered, time-tagged event stream. Events dropped on FIFO overflow are flagged, and a resynchronising record is forced once space returns.

## Interface

- NUM_SIGNALS, 16, width of command vector
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 records)
- TS_WIDTH, 16, timestamp counter width

- clk  in  1  clock
- sclr_n  in  1  reset; synchronous and active-low
- com_in  in  NUM_SIGNALS  filtered commands, active-low (1 = idle), already synchronous to clk
- tick  in  1  timestamp increment strobe, one clk wide
- rd_req  in  1  pop request
- rd_data  out  REC_W  record {ts, vector}; REC_W = TS_WIDTH+NUM_SIGNALS (see Configuration)
- rd_valid  out  1  rd_data valid, one-cycle pulse
- empty  out  1  FIFO empty
- full  out  1  FIFO holds 2^DEPTH_LOG2 records
- level  out  DEPTH_LOG2+1  number of stored records
- overflow  out  1  sticky flag: at least one record was dropped
- ovf_clr  in  1  clears overflow

## Operation

- Reset (sclr_n=0 at a clk edge):
  - prev = all ones; ts = 0; FIFO empty; resync = 0.
  - Outputs: level=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0.
- Change detect: push_req = (com_in != prev) | (resync & ~full_eff).
  - prev <= com_in every cycle, whether or not the record is accepted.
- Timestamp: ts increments by 1 on each tick, wrapping modulo 2^TS_WIDTH.
  - A record captures the pre-increment ts of its cycle.
- Push acceptance: accepted when level < DEPTH, or when level == DEPTH and a pop is accepted in the same cycle (full_eff = full & ~pop).
- Record content: {ts, com_in}; ts in the MSBs.
- Overflow handling: a change with full_eff=1 is dropped, sets overflow and sets resync.
  - While resync=1, the first cycle with full_eff=0 pushes {ts, com_in} even if no change occurs, then clears resync.
  - A real change in that cycle produces one record, not two.
- ovf_clr clears overflow. If a drop happens in the same cycle, set wins and overflow stays 1. ovf_clr does not affect resync.
- Pop: accepted when rd_req=1 and empty=0. rd_req while empty is ignored.
- Storage: circular buffer with DEPTH_LOG2-bit read and write pointers. Pointers wrap naturally; level is tracked separately.

## Timing

- com_in change in cycle N: record written at the end of N.
  - level, empty and full update in N+1.
  - The earliest pop of that record is rd_req in N+1.
- Pop: rd_req accepted in cycle M gives rd_data and rd_valid=1 in M+1.
  - rd_valid returns to 0 in M+2 unless another pop is accepted in M+1.
  - rd_data holds its last value while rd_valid=0.
- Back-to-back pops: rd_req held high drains one record per cycle.
- Simultaneous push and pop: level is unchanged.
  - With level=0 there is nothing to pop; the push lands and level becomes 1. No same-cycle fall-through.
- Consecutive changes N, N+1, ...: one record per cycle, no merging.
- Reset mid-operation: all queued records are discarded.
  - The first change-detect after reset compares against all ones, so a held-active command produces a record in the first cycle after reset.

## Configuration

- COM_EVENT_TS_EN defined:
  - ts counter present; REC_W = TS_WIDTH+NUM_SIGNALS.
  - Record = {ts, vector}.
- COM_EVENT_TS_EN undefined:
  - No ts counter; tick is ignored.
  - REC_W = NUM_SIGNALS; record = vector only.
  - All other behaviour is identical.

## Test plan

- Reset, then com_in=16'hFFFF held for 20 cycles: empty=1, level=0, no records, rd_req gives rd_valid=0.
- After 5 ticks (ts=5), com_in goes 16'hFFFF to 16'hFFFE: level=1 next cycle. rd_req then gives rd_data={16'd5,16'hFFFE} and rd_valid=1 for one cycle.
- 9 distinct changes on consecutive cycles with no reads, then com_in held:
  - 8 records stored; full=1; overflow=1.
  - One pop, then the next cycle pushes resync record {ts, current com_in}; level=8.
  - Drain order matches arrival order.
- Full FIFO with rd_req=1 and a change in the same cycle: change accepted, level stays 8, overflow stays 0.
- ts at 16'hFFFF, tick coincident with a change: record ts=16'hFFFF; the next change records ts=0.
- sclr_n=0 with 4 records queued, then released while com_in=16'hFF00: level=0 in the reset cycle, then one record with vector 16'hFF00 and ts=0.
